// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: redirect channels, hold bus, fetch request
// handshake and misalignment report.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int N_REDIR = 2,
    parameter int HOLD_W  = 3
);
    logic [N_REDIR-1:0]        redir_valid;
    logic [N_REDIR*ADDR_W-1:0] redir_addr;
    logic [HOLD_W-1:0]         hold_flag;
    logic                      fetch_valid;
    logic [ADDR_W-1:0]         fetch_addr;
    logic                      fetch_ready;
    logic                      fetch_epoch;
    logic                      misalign_err;
    logic [ADDR_W-1:0]         misalign_addr;

    // master: the PC generator; slave: control/ex stages plus instruction memory
    modport master (
        input  redir_valid, redir_addr, hold_flag, fetch_ready,
        output fetch_valid, fetch_addr, fetch_epoch, misalign_err, misalign_addr
    );
    modport slave (
        output redir_valid, redir_addr, hold_flag, fetch_ready,
        input  fetch_valid, fetch_addr, fetch_epoch, misalign_err, misalign_addr
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: valid/ready request port, prioritised
// redirects with an epoch bit, hold gating and a halt on misaligned targets.
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                N_REDIR    = 2,
    parameter int                STEP       = 4,
    parameter int                ALIGN_BITS = 2,
    parameter int                HOLD_W     = 3,
    parameter int                HOLD_BIT   = 0
) (
    input logic       clk,
    input logic       rst,
    pc_gen_if.master  bus
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'(1) << ALIGN_BITS) - 64'(1));
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t            state;
    logic              redir_hit;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redir_mis;
    logic              hold;
    logic              accept;

    // Walk from the lowest priority upward so channel 0 is written last and wins.
    always_comb begin
        redir_hit = 1'b0;
        redir_tgt = '0;
        for (int i = N_REDIR - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                redir_hit = 1'b1;
                redir_tgt = bus.redir_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign redir_mis = |(redir_tgt & ALIGN_MASK);
    assign hold      = bus.hold_flag[HOLD_BIT];
    assign accept    = bus.fetch_valid && bus.fetch_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            bus.fetch_valid   <= 1'b0;
            bus.fetch_addr    <= RESET_VEC;
            bus.fetch_epoch   <= 1'b0;
            bus.misalign_err  <= 1'b0;
            bus.misalign_addr <= '0;
        end else begin
            bus.misalign_err <= 1'b0;
            if (redir_hit) begin
                // Any redirect kills in-flight responses, even one that halts.
                bus.fetch_epoch <= ~bus.fetch_epoch;
                if (redir_mis) begin
                    state             <= S_HALT;
                    bus.fetch_valid   <= 1'b0;
                    bus.misalign_err  <= 1'b1;
                    bus.misalign_addr <= redir_tgt;
                end else begin
                    state           <= S_RUN;
                    bus.fetch_valid <= 1'b1;
                    bus.fetch_addr  <= redir_tgt;
                end
            end else begin
                case (state)
                    S_IDLE: state <= S_RUN;
                    S_RUN: begin
                        // A pending request is never retracted by hold.
                        if (!(hold && bus.fetch_valid && !bus.fetch_ready)) begin
                            if (accept) bus.fetch_addr <= bus.fetch_addr + STEP_INC;
                            bus.fetch_valid <= !hold;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed walk of the fetch scenarios followed by
// randomized traffic, checked cycle by cycle against a behavioural model.
module tb_pc_gen;
    localparam int          AW = 32;
    localparam int          NR = 2;
    localparam logic [31:0] RV = 32'h0;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        epoch;
        logic        err;
        logic [31:0] maddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(AW), .N_REDIR(NR), .HOLD_W(3)) bus ();

    pc_gen #(.ADDR_W(AW), .RESET_VEC(RV), .N_REDIR(NR), .STEP(4),
             .ALIGN_BITS(2), .HOLD_W(3), .HOLD_BIT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: PC, request flag, epoch, halt flag and cycles since reset.
    logic [31:0] m_addr = RV, m_maddr = '0;
    bit          m_valid = 0, m_epoch = 0, m_err = 0, m_halt = 0;
    int          m_since = 0;

    task automatic model(input bit r, input logic [NR-1:0] rv, input logic [NR*32-1:0] ra,
                         input logic [2:0] h, input bit rdy);
        bit          hit = 0;
        logic [31:0] tgt = '0;
        if (r) begin
            m_addr = RV; m_valid = 0; m_epoch = 0; m_err = 0; m_maddr = '0;
            m_halt = 0; m_since = 0;
            return;
        end
        for (int i = 0; i < NR; i++)
            if (rv[i] && !hit) begin hit = 1; tgt = ra[i*32 +: 32]; end
        m_err = 0;
        if (hit) begin
            m_epoch = !m_epoch;
            m_since = 2;
            if (tgt % 4 != 0) begin
                m_valid = 0; m_err = 1; m_maddr = tgt; m_halt = 1;
            end else begin
                m_addr = tgt; m_valid = 1; m_halt = 0;
            end
        end else if (m_halt) begin
            // halted: wait for an aligned redirect
        end else if (m_since == 0) begin
            m_since = 1;
        end else begin
            m_since = 2;
            if (!(h[0] && m_valid && !rdy)) begin
                if (m_valid && rdy) m_addr = m_addr + 32'd4;
                m_valid = !h[0];
            end
        end
    endtask

    task automatic step(input bit r, input logic [1:0] rv, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [2:0] h, input bit rdy);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.redir_valid = rv;
        bus.redir_addr  = {a1, a0};
        bus.hold_flag   = h;
        bus.fetch_ready = rdy;
        model(r, rv, {a1, a0}, h, rdy);
        e = '{valid: m_valid, addr: m_addr, epoch: m_epoch, err: m_err, maddr: m_maddr};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fetch_valid",   32'(bus.fetch_valid),  32'(e.valid));
            chk("fetch_addr",    bus.fetch_addr,        e.addr);
            chk("fetch_epoch",   32'(bus.fetch_epoch),  32'(e.epoch));
            chk("misalign_err",  32'(bus.misalign_err), 32'(e.err));
            chk("misalign_addr", bus.misalign_addr,     e.maddr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] a0, a1;
        logic [1:0]  rv;
        bus.redir_valid = '0;
        bus.redir_addr  = '0;
        bus.hold_flag   = '0;
        bus.fetch_ready = 1'b0;

        // reset, then free-running stream up to 0x10
        repeat (3) step(1, 2'b00, 0, 0, 3'b000, 1);
        for (int k = 0; k < 40 && !(m_valid && m_addr == 32'h10); k++)
            step(0, 2'b00, 0, 0, 3'b000, 1);
        // backpressure at 0x10, then accept
        repeat (3) step(0, 2'b00, 0, 0, 3'b000, 0);
        step(0, 2'b00, 0, 0, 3'b000, 1);
        step(0, 2'b00, 0, 0, 3'b000, 0);
        // both channels redirect with a pending request: channel 0 wins
        step(0, 2'b11, 32'h100, 32'h200, 3'b000, 0);
        step(0, 2'b00, 0, 0, 3'b000, 0);
        // misaligned beats aligned lower channel, then halt under ready=1 and hold
        step(0, 2'b11, 32'h102, 32'h204, 3'b000, 1);
        repeat (5) step(0, 2'b00, 0, 0, 3'b001, 1);
        step(0, 2'b10, 0, 32'h300, 3'b000, 1);
        step(0, 2'b00, 0, 0, 3'b000, 1);
        // hold with nothing outstanding at 0x40
        step(0, 2'b01, 32'h3C, 0, 3'b000, 0);
        step(0, 2'b00, 0, 0, 3'b001, 1);
        repeat (4) step(0, 2'b00, 0, 0, 3'b111, 1);
        step(0, 2'b00, 0, 0, 3'b000, 0);
        // hold arriving on a pending request keeps it until accepted
        repeat (2) step(0, 2'b00, 0, 0, 3'b001, 0);
        step(0, 2'b00, 0, 0, 3'b001, 1);
        step(0, 2'b00, 0, 0, 3'b001, 1);
        // wrap at the top of the address space
        step(0, 2'b01, 32'hFFFF_FFFC, 0, 3'b000, 0);
        step(0, 2'b00, 0, 0, 3'b000, 1);
        step(0, 2'b00, 0, 0, 3'b000, 0);
        // reset during a pending request plus redirect
        step(1, 2'b01, 32'h500, 0, 3'b000, 1);
        repeat (3) step(0, 2'b00, 0, 0, 3'b000, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rv = '0;
            if ($urandom_range(15) == 0) rv[0] = 1'b1;
            if ($urandom_range(15) == 0) rv[1] = 1'b1;
            a0 = $urandom();
            a1 = $urandom();
            if ($urandom_range(3) != 0) a0[1:0] = 2'b00;
            if ($urandom_range(3) != 0) a1[1:0] = 2'b00;
            if ($urandom_range(7) == 0) a0 = 32'hFFFF_FFF0;
            step($urandom_range(99) == 0, rv, a0, a1, 3'($urandom_range(7) & ($urandom_range(1) ? 7 : 6)),
                 $urandom_range(2) != 0);
        end

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
